// File: rtl/cache_set_array_pkg.sv
// Shared types and width helpers for the N-way set-associative line store.
// Optional feature macro: CACHE_SET_ARRAY_FLUSH_EN (adds the FLUSH state).
package cache_set_array_pkg;

    // Default geometry; the top module takes these as parameter defaults.
    localparam int DEF_NUM_SETS   = 16;
    localparam int DEF_NUM_WAYS   = 4;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 1024;

    // Byte-offset bits inside one line.
    function automatic int offset_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Set-index bits.
    function automatic int index_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    // Remaining upper address bits form the tag.
    function automatic int tag_bits(input int addr_width, input int num_sets, input int data_width);
        return addr_width - index_bits(num_sets) - offset_bits(data_width);
    endfunction

    localparam int DEF_OFFSET_BITS = offset_bits(DEF_DATA_WIDTH);
    localparam int DEF_INDEX_BITS  = index_bits(DEF_NUM_SETS);
    localparam int DEF_TAG_BITS    = tag_bits(DEF_ADDR_WIDTH, DEF_NUM_SETS, DEF_DATA_WIDTH);

    typedef logic [DEF_DATA_WIDTH-1:0] def_line_t;
    typedef logic [DEF_TAG_BITS-1:0]   def_tag_t;
    typedef logic [DEF_INDEX_BITS-1:0] def_index_t;

    // Sequencer states; encoding is exposed on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_EVICT  = 3'd2,
        ST_REFILL = 3'd3,
        ST_RESP   = 3'd4
`ifdef CACHE_SET_ARRAY_FLUSH_EN
        ,
        ST_FLUSH  = 3'd5
`endif
    } state_e;

endpackage

// File: rtl/cache_set_array_plru.sv
// Tree pseudo-LRU for one set: victim walk and post-access update vector.
// Node layout is heap order (root 0, children 2n+1 / 2n+2). A node bit of 0
// points the victim search left, 1 points it right.
module plru_tree #(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0]         tree_bits,
    input  logic [$clog2(NUM_WAYS)-1:0] access_way,
    output logic [$clog2(NUM_WAYS)-1:0] victim_way,
    output logic [NUM_WAYS-2:0]         next_bits
);
    localparam int WAY_BITS = $clog2(NUM_WAYS);
    localparam logic [NUM_WAYS-2:0] NODE_ONE = (NUM_WAYS-1)'(1);

    // Follow node bits from the root; each level yields one victim index bit (MSB first).
    always_comb begin
        int                  node;
        logic [NUM_WAYS-2:0] shifted;
        victim_way = '0;
        shifted    = '0;
        node       = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            shifted    = tree_bits >> node;
            victim_way = (victim_way << 1) | WAY_BITS'(shifted[0]);
            node       = 2 * node + 1 + int'(shifted[0]);
        end
    end

    // Walk the accessed way's path and point every node on it away from that way.
    always_comb begin
        int                  node;
        logic [WAY_BITS-1:0] way_sh;
        logic                dir;
        next_bits = tree_bits;
        way_sh    = '0;
        dir       = 1'b0;
        node      = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            way_sh    = access_way >> (WAY_BITS - 1 - l);
            dir       = way_sh[0];
            next_bits = (next_bits & ~(NODE_ONE << node)) | ((NUM_WAYS-1)'(~dir) << node);
            node      = 2 * node + 1 + int'(dir);
        end
    end

endmodule

// File: rtl/cache_set_array.sv
// N-way set-associative line store with tag compare, byte-enable writes,
// tree-PLRU replacement and a write-back / refill sequencer.
// Optional feature macro: CACHE_SET_ARRAY_FLUSH_EN (flush_i / flush_done_o).
// Handshakes: a request transfers on a cycle where req_valid_i & req_ready_o;
// a victim transfers on evict_valid_o & evict_ready_i, with payload held
// stable while valid waits; refill_req_o is a level held with a stable
// address until the one-cycle refill_valid_i pulse.
module cache_set_array
    import cache_set_array_pkg::*;
#(
    parameter int NUM_SETS   = DEF_NUM_SETS,
    parameter int NUM_WAYS   = DEF_NUM_WAYS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    output logic                    rsp_valid_o,
    output logic                    rsp_hit_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    evict_valid_o,
    input  logic                    evict_ready_i,
    output logic [ADDR_WIDTH-1:0]   evict_addr_o,
    output logic [DATA_WIDTH-1:0]   evict_data_o,
    output logic                    refill_req_o,
    output logic [ADDR_WIDTH-1:0]   refill_addr_o,
    input  logic                    refill_valid_i,
    input  logic [DATA_WIDTH-1:0]   refill_data_i,
`ifdef CACHE_SET_ARRAY_FLUSH_EN
    input  logic                    flush_i,
    output logic                    flush_done_o,
`endif
    output logic [2:0]              state_o
);
    localparam int OFFSET_BITS = offset_bits(DATA_WIDTH);
    localparam int INDEX_BITS  = index_bits(NUM_SETS);
    localparam int TAG_BITS    = tag_bits(ADDR_WIDTH, NUM_SETS, DATA_WIDTH);
    localparam int BE_BITS     = DATA_WIDTH / 8;
    localparam int WAY_BITS    = $clog2(NUM_WAYS);

    typedef logic [DATA_WIDTH-1:0] line_t;
    typedef logic [TAG_BITS-1:0]   tag_t;
    typedef logic [INDEX_BITS-1:0] index_t;
    typedef logic [WAY_BITS-1:0]   way_t;
    typedef logic [BE_BITS-1:0]    be_t;

    state_e state_q;

    // Captured request
    logic   req_we_q;
    tag_t   req_tag_q;
    index_t req_index_q;
    line_t  req_wdata_q;
    be_t    req_be_q;
    way_t   victim_q;

    // Set array
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    tag_t                tag_q   [NUM_SETS][NUM_WAYS];
    line_t               data_q  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];

`ifdef CACHE_SET_ARRAY_FLUSH_EN
    index_t flush_set_q;
    way_t   flush_way_q;
    logic   flushing_q;
`endif

    logic  hit_any;
    way_t  hit_way;
    logic  any_inv;
    way_t  first_inv;
    way_t  plru_victim;
    way_t  miss_victim;
    way_t  access_way;
    logic  victim_dirty;
    logic [NUM_WAYS-2:0] plru_next;
    line_t hit_merged;
    line_t refill_merged;

    // Offset bits of the request address do not select anything.
    logic unused_offset;
    assign unused_offset = ^req_addr_i[OFFSET_BITS-1:0];

    assign state_o = state_q;

    // Overwrite the bytes of old_line whose enable is set with new_line's bytes.
    function automatic line_t merge_line(input line_t old_line, input line_t new_line, input be_t be);
        line_t r;
        r = old_line;
        for (int b = 0; b < BE_BITS; b++) begin
            if (be[b]) r[b*8 +: 8] = new_line[b*8 +: 8];
        end
        return r;
    endfunction

    // Tag compare over the indexed set plus lowest-index invalid way (descending scan so low wins).
    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        any_inv   = 1'b0;
        first_inv = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_index_q][w] && (tag_q[req_index_q][w] == req_tag_q)) begin
                hit_any = 1'b1;
                hit_way = way_t'(w);
            end
            if (!valid_q[req_index_q][w]) begin
                any_inv   = 1'b1;
                first_inv = way_t'(w);
            end
        end
    end

    assign miss_victim  = any_inv ? first_inv : plru_victim;
    assign victim_dirty = valid_q[req_index_q][miss_victim] && dirty_q[req_index_q][miss_victim];
    assign access_way   = (state_q == ST_LOOKUP) ? hit_way : victim_q;
    assign hit_merged   = req_we_q ? merge_line(data_q[req_index_q][hit_way], req_wdata_q, req_be_q)
                                   : data_q[req_index_q][hit_way];
    assign refill_merged = req_we_q ? merge_line(refill_data_i, req_wdata_q, req_be_q) : refill_data_i;

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .tree_bits  (plru_q[req_index_q]),
        .access_way (access_way),
        .victim_way (plru_victim),
        .next_bits  (plru_next)
    );

    // Sequencer, set-array storage and registered outputs.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q       <= ST_IDLE;
            req_we_q      <= 1'b0;
            req_tag_q     <= '0;
            req_index_q   <= '0;
            req_wdata_q   <= '0;
            req_be_q      <= '0;
            victim_q      <= '0;
            req_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_hit_o     <= 1'b0;
            rsp_rdata_o   <= '0;
            evict_valid_o <= 1'b0;
            evict_addr_o  <= '0;
            evict_data_o  <= '0;
            refill_req_o  <= 1'b0;
            refill_addr_o <= '0;
`ifdef CACHE_SET_ARRAY_FLUSH_EN
            flush_set_q   <= '0;
            flush_way_q   <= '0;
            flushing_q    <= 1'b0;
            flush_done_o  <= 1'b0;
`endif
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                end
            end
        end else begin
            rsp_valid_o <= 1'b0;
`ifdef CACHE_SET_ARRAY_FLUSH_EN
            flush_done_o <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
`ifdef CACHE_SET_ARRAY_FLUSH_EN
                    if (flush_i) begin
                        req_ready_o <= 1'b0;
                        flush_set_q <= '0;
                        flush_way_q <= '0;
                        flushing_q  <= 1'b1;
                        state_q     <= ST_FLUSH;
                    end else
`endif
                    if (req_valid_i) begin
                        req_we_q    <= req_we_i;
                        req_tag_q   <= req_addr_i[ADDR_WIDTH-1 -: TAG_BITS];
                        req_index_q <= req_addr_i[OFFSET_BITS +: INDEX_BITS];
                        req_wdata_q <= req_wdata_i;
                        req_be_q    <= req_be_i;
                        req_ready_o <= 1'b0;
                        state_q     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit_any) begin
                        if (req_we_q) begin
                            data_q[req_index_q][hit_way]  <= hit_merged;
                            dirty_q[req_index_q][hit_way] <= 1'b1;
                        end
                        plru_q[req_index_q] <= plru_next;
                        rsp_hit_o           <= 1'b1;
                        rsp_rdata_o         <= hit_merged;
                        rsp_valid_o         <= 1'b1;
                        state_q             <= ST_RESP;
                    end else begin
                        victim_q      <= miss_victim;
                        refill_addr_o <= {req_tag_q, req_index_q, {OFFSET_BITS{1'b0}}};
                        if (victim_dirty) begin
                            evict_valid_o <= 1'b1;
                            evict_addr_o  <= {tag_q[req_index_q][miss_victim], req_index_q,
                                              {OFFSET_BITS{1'b0}}};
                            evict_data_o  <= data_q[req_index_q][miss_victim];
                            state_q       <= ST_EVICT;
                        end else begin
                            refill_req_o <= 1'b1;
                            state_q      <= ST_REFILL;
                        end
                    end
                end
                ST_EVICT: begin
                    if (evict_ready_i) begin
                        evict_valid_o <= 1'b0;
`ifdef CACHE_SET_ARRAY_FLUSH_EN
                        if (flushing_q) begin
                            // Written back; the FLUSH state then invalidates the now-clean line.
                            dirty_q[flush_set_q][flush_way_q] <= 1'b0;
                            state_q <= ST_FLUSH;
                        end else
`endif
                        begin
                            refill_req_o <= 1'b1;
                            state_q      <= ST_REFILL;
                        end
                    end
                end
                ST_REFILL: begin
                    if (refill_valid_i) begin
                        tag_q[req_index_q][victim_q]   <= req_tag_q;
                        valid_q[req_index_q][victim_q] <= 1'b1;
                        dirty_q[req_index_q][victim_q] <= req_we_q;
                        data_q[req_index_q][victim_q]  <= refill_merged;
                        plru_q[req_index_q]            <= plru_next;
                        refill_req_o                   <= 1'b0;
                        rsp_hit_o                      <= 1'b0;
                        rsp_rdata_o                    <= refill_merged;
                        rsp_valid_o                    <= 1'b1;
                        state_q                        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    req_ready_o <= 1'b1;
                    state_q     <= ST_IDLE;
                end
`ifdef CACHE_SET_ARRAY_FLUSH_EN
                ST_FLUSH: begin
                    if (valid_q[flush_set_q][flush_way_q] && dirty_q[flush_set_q][flush_way_q]) begin
                        evict_valid_o <= 1'b1;
                        evict_addr_o  <= {tag_q[flush_set_q][flush_way_q], flush_set_q,
                                          {OFFSET_BITS{1'b0}}};
                        evict_data_o  <= data_q[flush_set_q][flush_way_q];
                        state_q       <= ST_EVICT;
                    end else begin
                        valid_q[flush_set_q][flush_way_q] <= 1'b0;
                        dirty_q[flush_set_q][flush_way_q] <= 1'b0;
                        if (flush_way_q == way_t'(NUM_WAYS - 1)) begin
                            flush_way_q <= '0;
                            if (flush_set_q == index_t'(NUM_SETS - 1)) begin
                                flushing_q   <= 1'b0;
                                flush_done_o <= 1'b1;
                                req_ready_o  <= 1'b1;
                                state_q      <= ST_IDLE;
                            end else begin
                                flush_set_q <= flush_set_q + index_t'(1);
                            end
                        end else begin
                            flush_way_q <= flush_way_q + way_t'(1);
                        end
                    end
                end
`endif
                default: begin
                    req_ready_o <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_set_array.sv
// Directed bench for cache_set_array (4 sets, 2 ways, 16-bit address, 64-bit line).
// Expected responses are queued when a request is driven and popped on rsp_valid_o.
module tb_cache_set_array;
    localparam int NS = 4;
    localparam int NW = 2;
    localparam int AW = 16;
    localparam int DW = 64;

    logic          clk_i = 1'b0;
    logic          arst_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_we_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic [7:0]    req_be_i = '0;
    logic          rsp_valid_o;
    logic          rsp_hit_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          evict_valid_o;
    logic          evict_ready_i = 1'b0;
    logic [AW-1:0] evict_addr_o;
    logic [DW-1:0] evict_data_o;
    logic          refill_req_o;
    logic [AW-1:0] refill_addr_o;
    logic          refill_valid_i = 1'b0;
    logic [DW-1:0] refill_data_i = '0;
    logic [2:0]    state_o;
`ifdef CACHE_SET_ARRAY_FLUSH_EN
    logic          flush_i = 1'b0;
    logic          flush_done_o;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int ref_cyc = 0;

    logic [DW-1:0] exp_q[$];
    logic          exp_hit_q[$];

    cache_set_array #(
        .NUM_SETS(NS), .NUM_WAYS(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk_i          (clk_i),
        .arst_ni        (arst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_be_i       (req_be_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_hit_o      (rsp_hit_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .evict_valid_o  (evict_valid_o),
        .evict_ready_i  (evict_ready_i),
        .evict_addr_o   (evict_addr_o),
        .evict_data_o   (evict_data_o),
        .refill_req_o   (refill_req_o),
        .refill_addr_o  (refill_addr_o),
        .refill_valid_i (refill_valid_i),
        .refill_data_i  (refill_data_i),
`ifdef CACHE_SET_ARRAY_FLUSH_EN
        .flush_i        (flush_i),
        .flush_done_o   (flush_done_o),
`endif
        .state_o        (state_o)
    );

    // Clock and cycle counter
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request; optionally queue its expected response.
    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [7:0] be, input logic push, input logic exp_hit,
                        input logic [DW-1:0] exp_data);
        int n;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("req_ready", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        acc_cyc     = cyc;
        if (push) begin
            exp_q.push_back(exp_data);
            exp_hit_q.push_back(exp_hit);
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_be_i    = '0;
    endtask

    // Wait for a refill request, check its address and that no evict appeared, then deliver data.
    task automatic do_refill(input logic [AW-1:0] exp_addr, input logic [DW-1:0] data);
        int   n;
        logic ev_seen;
        n = 0;
        ev_seen = 1'b0;
        while (refill_req_o !== 1'b1 && n < 50) begin
            ev_seen = ev_seen | evict_valid_o;
            @(negedge clk_i);
            n++;
        end
        check("refill_req", refill_req_o, 1);
        check("refill_addr", refill_addr_o, exp_addr);
        check("no_evict_during_refill", ev_seen | evict_valid_o, 0);
        refill_valid_i = 1'b1;
        refill_data_i  = data;
        ref_cyc        = cyc;
        @(negedge clk_i);
        refill_valid_i = 1'b0;
        refill_data_i  = '0;
    endtask

    // Wait for a victim, check payload, hold it off for 'hold' cycles, then accept.
    task automatic do_evict(input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_data, input int hold);
        int n;
        n = 0;
        while (evict_valid_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("evict_valid", evict_valid_o, 1);
        check("evict_addr", evict_addr_o, exp_addr);
        check("evict_data", evict_data_o, exp_data);
        check("no_refill_during_evict", refill_req_o, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            check("evict_hold_valid", evict_valid_o, 1);
            check("evict_hold_addr", evict_addr_o, exp_addr);
            check("evict_hold_data", evict_data_o, exp_data);
        end
        evict_ready_i = 1'b1;
        @(negedge clk_i);
        evict_ready_i = 1'b0;
        check("evict_drop", evict_valid_o, 0);
    endtask

    // Pop the scoreboard on the response pulse; check latency from 'from_cyc' and pulse width.
    task automatic wait_rsp(input int exp_lat, input int from_cyc);
        int            n;
        logic [DW-1:0] ed;
        logic          eh;
        n = 0;
        while (rsp_valid_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("rsp_valid", rsp_valid_o, 1);
        ed = '0;
        eh = 1'b0;
        if (exp_q.size() > 0) begin
            ed = exp_q.pop_front();
            eh = exp_hit_q.pop_front();
        end
        check("rsp_hit", rsp_hit_o, eh);
        check("rsp_rdata", rsp_rdata_o, ed);
        check("rsp_latency", 64'(cyc - from_cyc), 64'(exp_lat));
        @(negedge clk_i);
        check("rsp_pulse", rsp_valid_o, 0);
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk_i);
        check("rst_ready", req_ready_o, 1);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_evict_valid", evict_valid_o, 0);
        check("rst_refill_req", refill_req_o, 0);
        arst_ni = 1'b1;
        @(negedge clk_i);
        check("idle_state", state_o, 0);
        check("idle_ready", req_ready_o, 1);

        // 1: cold read miss, refill, then hit reread with 2-cycle latency
        send(1'b0, 16'h0040, '0, 8'h00, 1'b1, 1'b0, 64'h1122334455667788);
        do_refill(16'h0040, 64'h1122334455667788);
        wait_rsp(1, ref_cyc);
        send(1'b0, 16'h0040, '0, 8'h00, 1'b1, 1'b1, 64'h1122334455667788);
        wait_rsp(2, acc_cyc);

        // 2: partial write hit makes the line dirty
        send(1'b1, 16'h0040, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b1, 1'b1, 64'h11223344AAAAAAAA);
        wait_rsp(2, acc_cyc);

        // 3: second tag in set 0 fills way1 without evicting the dirty way0
        send(1'b0, 16'h0140, '0, 8'h00, 1'b1, 1'b0, 64'hCAFEF00D12345678);
        do_refill(16'h0140, 64'hCAFEF00D12345678);
        wait_rsp(1, ref_cyc);
        send(1'b0, 16'h0140, '0, 8'h00, 1'b1, 1'b1, 64'hCAFEF00D12345678);
        wait_rsp(2, acc_cyc);
        // third tag: PLRU picks way0 (dirty) -> write-back held off 3 cycles
        send(1'b0, 16'h0240, '0, 8'h00, 1'b1, 1'b0, 64'h0F0E0D0C0B0A0908);
        do_evict(16'h0040, 64'h11223344AAAAAAAA, 3);
        do_refill(16'h0240, 64'h0F0E0D0C0B0A0908);
        wait_rsp(1, ref_cyc);
        send(1'b0, 16'h0140, '0, 8'h00, 1'b1, 1'b1, 64'hCAFEF00D12345678);
        wait_rsp(2, acc_cyc);

        // 4: set 1, write miss merges into refill data; invalid way filled next without evict
        send(1'b1, 16'h0048, 64'h5555555555555555, 8'hF0, 1'b1, 1'b0, 64'h5555555589ABCDEF);
        do_refill(16'h0048, 64'h0123456789ABCDEF);
        wait_rsp(1, ref_cyc);
        send(1'b0, 16'h0148, '0, 8'h00, 1'b1, 1'b0, 64'hDEADBEEF00000001);
        do_refill(16'h0148, 64'hDEADBEEF00000001);
        wait_rsp(1, ref_cyc);
        send(1'b0, 16'h0048, '0, 8'h00, 1'b1, 1'b1, 64'h5555555589ABCDEF);
        wait_rsp(2, acc_cyc);
        // be=0 write: data unchanged but the line becomes dirty
        send(1'b1, 16'h0148, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b1, 1'b1, 64'hDEADBEEF00000001);
        wait_rsp(2, acc_cyc);
        send(1'b0, 16'h0048, '0, 8'h00, 1'b1, 1'b1, 64'h5555555589ABCDEF);
        wait_rsp(2, acc_cyc);
        send(1'b0, 16'h0248, '0, 8'h00, 1'b1, 1'b0, 64'h7777777777777777);
        do_evict(16'h0148, 64'hDEADBEEF00000001, 0);
        do_refill(16'h0248, 64'h7777777777777777);
        wait_rsp(1, ref_cyc);

        // 5: reset while waiting on a refill
        send(1'b0, 16'h0340, '0, 8'h00, 1'b0, 1'b0, '0);
        begin
            int n;
            n = 0;
            while (refill_req_o !== 1'b1 && n < 50) begin
                @(negedge clk_i);
                n++;
            end
        end
        check("pre_reset_refill_req", refill_req_o, 1);
        arst_ni = 1'b0;
        #1;
        check("mid_reset_refill_req", refill_req_o, 0);
        check("mid_reset_state", state_o, 0);
        @(negedge clk_i);
        arst_ni = 1'b1;
        @(negedge clk_i);
        check("post_reset_ready", req_ready_o, 1);
        // stray refill pulse in IDLE is ignored
        refill_valid_i = 1'b1;
        refill_data_i  = 64'hBADBADBADBADBAD0;
        @(negedge clk_i);
        refill_valid_i = 1'b0;
        refill_data_i  = '0;
        check("stray_refill_state", state_o, 0);
        check("stray_refill_rsp", rsp_valid_o, 0);
        send(1'b0, 16'h0040, '0, 8'h00, 1'b1, 1'b0, 64'h0102030405060708);
        do_refill(16'h0040, 64'h0102030405060708);
        wait_rsp(1, ref_cyc);

`ifdef CACHE_SET_ARRAY_FLUSH_EN
        // 6: flush with two dirty lines resident
        send(1'b1, 16'h0140, 64'h1111111111111111, 8'hFF, 1'b1, 1'b0, 64'h1111111111111111);
        do_refill(16'h0140, 64'h2222222222222222);
        wait_rsp(1, ref_cyc);
        send(1'b1, 16'h0048, 64'h3333333333333333, 8'hFF, 1'b1, 1'b0, 64'h3333333333333333);
        do_refill(16'h0048, 64'h4444444444444444);
        wait_rsp(1, ref_cyc);
        begin
            int   ev_cnt;
            int   done_cnt;
            logic ready_seen;
            ev_cnt     = 0;
            done_cnt   = 0;
            ready_seen = 1'b0;
            flush_i = 1'b1;
            @(negedge clk_i);
            flush_i = 1'b0;
            evict_ready_i = 1'b1;
            for (int i = 0; i < 60; i++) begin
                if (evict_valid_o === 1'b1) ev_cnt++;
                if (flush_done_o === 1'b1) done_cnt++;
                else if (done_cnt == 0 && req_ready_o === 1'b1) ready_seen = 1'b1;
                @(negedge clk_i);
            end
            evict_ready_i = 1'b0;
            check("flush_evicts", 64'(ev_cnt), 2);
            check("flush_done_pulses", 64'(done_cnt), 1);
            check("flush_ready_low", ready_seen, 0);
        end
        send(1'b0, 16'h0040, '0, 8'h00, 1'b1, 1'b0, 64'h5A5A5A5A5A5A5A5A);
        do_refill(16'h0040, 64'h5A5A5A5A5A5A5A5A);
        wait_rsp(1, ref_cyc);
        send(1'b0, 16'h0048, '0, 8'h00, 1'b1, 1'b0, 64'hA5A5A5A5A5A5A5A5);
        do_refill(16'h0048, 64'hA5A5A5A5A5A5A5A5);
        wait_rsp(1, ref_cyc);
`endif

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_set_array.md
Name: cache_set_array

Overview:
- Parametrised N-way set-associative line store, generalising the single-row tag/valid/dirty/data register group into a full set array.
- Adds tag compare, hit/miss detection, byte-enable writes, tree-PLRU replacement and a write-back/refill sequencer.
- Sits between a core-side line request port and the memory-side evict/refill ports of the L1 data cache.

Parameters:
- NUM_SETS, 16, sets (power of 2, >=2).
- NUM_WAYS, 4, ways per set (power of 2, >=2).
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 1024, line width in bits (multiple of 8, power of 2).
- Derived localparams: OFFSET_BITS = log2(DATA_WIDTH/8), INDEX_BITS = log2(NUM_SETS), TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS.

Ports:
- clk_i  in  1  clock.
- arst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid & ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  byte address; offset bits ignored.
- req_wdata_i  in  DATA_WIDTH  write line.
- req_be_i  in  DATA_WIDTH/8  byte enables.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_hit_o  out  1  1 = request hit.
- rsp_rdata_o  out  DATA_WIDTH  line contents after any write merge.
- evict_valid_o  out  1  dirty victim pending.
- evict_ready_i  in  1  memory accepts victim.
- evict_addr_o  out  ADDR_WIDTH  victim address {tag, index, 0}.
- evict_data_o  out  DATA_WIDTH  victim line.
- refill_req_o  out  1  level; line fetch requested.
- refill_addr_o  out  ADDR_WIDTH  line-aligned miss address.
- refill_valid_i  in  1  one-cycle pulse; refill data valid.
- refill_data_i  in  DATA_WIDTH  refill line.

Behaviour:
- Reset clears:
  - every valid, dirty, tag, data and PLRU bit to 0;
  - the FSM to IDLE;
  - rsp_valid_o, evict_valid_o and refill_req_o to 0.
- req_ready_o = 1 in IDLE only, so it is 1 out of reset.
- FSM states: IDLE, LOOKUP, EVICT, REFILL, RESP.
- IDLE:
  - On accept, register we/addr/wdata/be and go to LOOKUP.
- LOOKUP:
  - Compare the captured tag against all valid ways of the indexed set.
  - Hit: merge bytes where be=1 if we; set dirty if we; update PLRU toward the hit way; go to RESP.
  - Miss: choose victim as the lowest-index invalid way, else the PLRU victim.
  - Victim valid & dirty: go to EVICT. Otherwise go to REFILL.
- EVICT:
  - evict_valid_o = 1 with addr/data stable until evict_ready_i is seen.
  - Then go to REFILL.
- REFILL:
  - refill_req_o = 1 with refill_addr_o stable until refill_valid_i.
  - On refill_valid_i: write tag, valid = 1, dirty = we, and data = refill_data merged with wdata under be if we.
  - Update PLRU toward the victim way; go to RESP.
- RESP:
  - rsp_valid_o = 1 for exactly one cycle; rsp_hit_o = hit flag; rsp_rdata_o = final line.
  - Return to IDLE.
- Latency:
  - Hit: response 2 cycles after acceptance.
  - Clean miss: response 1 cycle after the refill_valid_i cycle.
- PLRU: NUM_WAYS-1 bits per set.
  - On access, each node on the path points away from the accessed way.
  - Victim is found by following the node bits.
- refill_valid_i outside REFILL and evict_ready_i outside EVICT are ignored.
- req_valid_i while not ready: no effect; the requester holds the request.
- Reset mid-operation (any state): immediate return to IDLE, all lines invalid. Pending evict/refill is dropped with no further handshake.
- be = 0 on a write: no data change, but dirty is still set.

Optional Feature:
- Macro: CACHE_SET_ARRAY_FLUSH_EN.
- Defined:
  - Adds ports flush_i (in, 1) and flush_done_o (out, 1-cycle pulse).
  - flush_i is accepted only in IDLE and has priority over req_valid_i.
  - A FLUSH state walks set 0..NUM_SETS-1, way 0..NUM_WAYS-1.
  - Each dirty line is written back via the EVICT handshake. Every line is invalidated and its dirty bit cleared.
  - flush_done_o pulses after the last way; then return to IDLE.
  - req_ready_o = 0 throughout the flush.
- Undefined: no ports, no FLUSH state.

Decomposition:
- Package cache_set_array_pkg:
  - state enum;
  - derived-width helper functions;
  - line/tag/index typedefs parametrised via localparams.
- Sub-module plru_tree (NUM_WAYS): combinational victim-select and update-vector logic, instantiated once on the indexed set's bits.

Test Plan:
Bench config: NUM_SETS=4, NUM_WAYS=2, ADDR_WIDTH=16, DATA_WIDTH=64.
1. After reset, read 0x0040 -> refill_req_o=1 with refill_addr_o=0x0040 and no evict. Refill 0x1122334455667788 -> rsp_hit_o=0, rdata=0x1122334455667788. Reread -> hit, rsp 2 cycles after accept.
2. Write 0x0040, be=0x0F, wdata=0xAAAAAAAAAAAAAAAA -> hit, rdata=0x11223344AAAAAAAA, line dirty.
3. Fill 0x0040 (dirty) and 0x0140 into set 0, reread 0x0140, then read 0x0240 -> victim way0. evict_addr_o=0x0040, evict_data_o=0x11223344AAAAAAAA; hold evict_ready_i=0 for 3 cycles -> payload stable.
4. Line in way1 only valid, miss to the same set -> way0 filled (invalid-first); no evict even if way1 is dirty.
5. Assert arst_ni low during REFILL -> refill_req_o=0 and req_ready_o=1 after release; reread 0x0040 misses.
6. With CACHE_SET_ARRAY_FLUSH_EN defined, 2 dirty lines resident, flush_i -> exactly 2 evict handshakes, flush_done_o pulses once, all subsequent reads miss.
